mem_resp: RTL and testbench

- Memory-side responder for the CPU data-memory access interface: address, active-low address strobe, read/write, write data, and read data.
- Serves word reads and writes from an internal synchronous word array.
- Inserts a configurable number of wait states and signals completion with an active-low ready.
- Sits on the bus between the MEM-stage access controller and on-chip data memory. It is the model for every slow memory the pipeline must stall on.

---
 rtl/mem_resp_pkg.sv | 36 +++
 rtl/mem_resp_ram.sv | 37 +++
 rtl/mem_resp.sv | 141 ++++++++++++++
 tb/tb_mem_resp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared bus definitions for the data-memory responder.
//   - Bus strobe / direction encodings (ENABLE_/DISABLE_, READ/WRITE).
//   - Word data / word address widths and types.
//   - Responder state encodings (MEM_RESP_ST_*) and wait-counter width.
//   - Helper that flags word addresses beyond the implemented array.
package mem_resp_pkg;

   // Active-low strobe levels
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   // Transfer direction on rw
   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   localparam int unsigned WORD_DATA_W = 32;
   localparam int unsigned WORD_ADDR_W = 30;
   localparam int unsigned WAIT_CNT_W  = 4;

   typedef logic [WORD_DATA_W-1:0] word_data_t;
   typedef logic [WORD_ADDR_W-1:0] word_addr_t;

   typedef enum logic [1:0] {
      MEM_RESP_ST_IDLE   = 2'd0,
      MEM_RESP_ST_WAIT   = 2'd1,
      MEM_RESP_ST_ACCESS = 2'd2,
      MEM_RESP_ST_RESP   = 2'd3
   } mem_resp_state_e;

   // True when any word-address bit at or above aw is set, i.e. the access
   // falls outside a 2**aw word array.
   function automatic logic addr_out_of_range(input word_addr_t a, input int unsigned aw);
      return (a >> aw) != '0;
   endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: single-port synchronous word RAM, 2**ADDR_W x 32.
//   clk    in   clock, rising edge
//   en     in   access enable
//   we     in   1 = write wdata to index, 0 = read index into rdata
//   index  in   word index
//   wdata  in   write data
//   rdata  out  registered read data; only updated by enabled reads
// No reset on the array or read register so tools can map it to block RAM.
module mem_resp_ram
   import mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] index,
   input  word_data_t        wdata,
   output word_data_t        rdata
);

   word_data_t mem_q [2**ADDR_W];
   word_data_t rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[index] <= wdata;
         end else begin
            rdata_q <= mem_q[index];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_resp.sv
// mem_resp: memory-side responder for the CPU data-memory access bus.
// Accepts one word read/write per request, inserts WAIT_CYCLES wait states,
// then performs the array access and pulses rdy_ low for one cycle.
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high reset
//   addr     in   word address (byte address [31:2])
//   as_      in   address strobe, active low
//   rw       in   READ = 1, WRITE = 0
//   wr_data  in   write data
//   rd_data  out  read data, registered; held until the next read's access
//   rdy_     out  ready, active low, one cycle per transaction
//   err      out  bus error, qualifies rdy_ = 0 for an out-of-range access
module mem_resp
   import mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 2   // legal range 0..15
) (
   input  logic       clk,
   input  logic       reset,
   input  word_addr_t addr,
   input  logic       as_,
   input  logic       rw,
   input  word_data_t wr_data,
   output word_data_t rd_data,
   output logic       rdy_,
   output logic       err
);

   mem_resp_state_e        state_q, state_d;
   logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   word_addr_t             addr_q, addr_d;
   logic                   rw_q, rw_d;
   word_data_t             wr_data_q, wr_data_d;
   logic                   rdy_q, rdy_d;
   logic                   err_q, err_d;
   // Forces rd_data to zero: after reset and after an out-of-range read.
   logic                   rd_zero_q, rd_zero_d;

   logic       oor;
   logic       ram_en;
   logic       ram_we;
   word_data_t ram_rdata;

   assign oor = addr_out_of_range(addr_q, ADDR_W);

   // Array is touched only in ACCESS and never for an out-of-range address,
   // so high address bits cannot alias onto low words.
   assign ram_en = (state_q == MEM_RESP_ST_ACCESS) && !oor;
   assign ram_we = (rw_q == WRITE);

   mem_resp_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .index (addr_q[ADDR_W-1:0]),
      .wdata (wr_data_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      wr_data_d  = wr_data_q;
      rdy_d      = DISABLE_;
      err_d      = 1'b0;
      rd_zero_d  = rd_zero_q;

      case (state_q)
         MEM_RESP_ST_IDLE: begin
            if (as_ == ENABLE_) begin
               addr_d     = addr;
               rw_d       = rw;
               wr_data_d  = wr_data;
               wait_cnt_d = WAIT_CNT_W'(WAIT_CYCLES);
               state_d    = (WAIT_CYCLES > 0) ? MEM_RESP_ST_WAIT : MEM_RESP_ST_ACCESS;
            end
         end

         MEM_RESP_ST_WAIT: begin
            wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
            // <= 1 rather than == 1 so a zero count can never stall here
            if (wait_cnt_q <= WAIT_CNT_W'(1)) begin
               state_d = MEM_RESP_ST_ACCESS;
            end
         end

         MEM_RESP_ST_ACCESS: begin
            // rdy_/err are registered, so they are set up here to be
            // presented during the RESP cycle.
            state_d = MEM_RESP_ST_RESP;
            rdy_d   = ENABLE_;
            err_d   = oor;
            if (rw_q == READ) begin
               rd_zero_d = oor;
            end
         end

         MEM_RESP_ST_RESP: begin
            state_d = MEM_RESP_ST_IDLE;
         end

         default: begin
            state_d = MEM_RESP_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= MEM_RESP_ST_IDLE;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         rw_q       <= READ;
         wr_data_q  <= '0;
         rdy_q      <= DISABLE_;
         err_q      <= 1'b0;
         rd_zero_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         wr_data_q  <= wr_data_d;
         rdy_q      <= rdy_d;
         err_q      <= err_d;
         rd_zero_q  <= rd_zero_d;
      end
   end

   // Both mux inputs come straight from flops, so rd_data stays registered;
   // the RAM read register is only reloaded by in-range reads.
   assign rd_data = rd_zero_q ? '0 : ram_rdata;
   assign rdy_    = rdy_q;
   assign err     = err_q;

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: scoreboard bench for mem_resp. Two instances are exercised:
// index 0 with WAIT_CYCLES = 0, index 1 with WAIT_CYCLES = 2.
module tb_mem_resp;
   import mem_resp_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] addr_v  [2];
   logic        as_v    [2];
   logic        rw_v    [2];
   logic [31:0] wd_v    [2];
   logic [31:0] rd_v    [2];
   logic        rdy_v   [2];
   logic        err_v   [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
      .clk     (clk),
      .reset   (reset),
      .addr    (addr_v[0]),
      .as_     (as_v[0]),
      .rw      (rw_v[0]),
      .wr_data (wd_v[0]),
      .rd_data (rd_v[0]),
      .rdy_    (rdy_v[0]),
      .err     (err_v[0])
   );

   mem_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut2 (
      .clk     (clk),
      .reset   (reset),
      .addr    (addr_v[1]),
      .as_     (as_v[1]),
      .rw      (rw_v[1]),
      .wr_data (wd_v[1]),
      .rd_data (rd_v[1]),
      .rdy_    (rdy_v[1]),
      .err     (err_v[1])
   );

   typedef struct {
      logic        is_rd;
      logic [31:0] data;
      logic        err;
      int          acc;
      int          lat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: every rdy_ low must match the oldest expected response.
   exp_t mon_e;
   logic mon_got;
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         for (int d = 0; d < 2; d++) begin
            if (rdy_v[d] === 1'b0) begin
               mon_got = 1'b0;
               if (d == 0 && q0.size() > 0) begin
                  mon_e = q0.pop_front(); mon_got = 1'b1;
               end else if (d == 1 && q1.size() > 0) begin
                  mon_e = q1.pop_front(); mon_got = 1'b1;
               end
               if (!mon_got) begin
                  chk($sformatf("unexpected_rdy dut%0d", d), 32'(rdy_v[d]), 32'd1);
               end else begin
                  chk($sformatf("latency dut%0d", d), cyc + 1 - mon_e.acc, mon_e.lat);
                  chk($sformatf("err dut%0d", d), 32'(err_v[d]), 32'(mon_e.err));
                  if (mon_e.is_rd) chk($sformatf("rd_data dut%0d", d), rd_v[d], mon_e.data);
               end
            end
         end
      end
   end

   // Issue one transaction; call at posedge+1 with the DUT idle.
   task automatic xfer(input int d, input logic r, input logic [29:0] a,
                       input logic [31:0] wd, input logic xe, input logic [31:0] xd,
                       input logic hold, input logic glitch, output int acc);
      exp_t e;
      logic got;
      as_v[d] = ENABLE_; rw_v[d] = r; addr_v[d] = a; wd_v[d] = wd;
      @(posedge clk); #1;
      acc     = cyc;
      e.is_rd = r;
      e.data  = xd;
      e.err   = xe;
      e.acc   = acc;
      e.lat   = (d == 0) ? 2 : 4;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      if (glitch) begin
         addr_v[d] = a ^ 30'h2AA; rw_v[d] = WRITE; wd_v[d] = 32'hBAD0_BAD0;
      end
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (rdy_v[d] === 1'b0) begin
            got = 1'b1;
            break;
         end
      end
      chk($sformatf("rdy_seen dut%0d addr %0h", d, a), 32'(got), 32'd1);
      @(posedge clk); #1;
      if (!hold) as_v[d] = DISABLE_;
   endtask

   int a1, a2, a3, acc;

   initial begin
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         as_v[d] = DISABLE_; addr_v[d] = '0; rw_v[d] = READ; wd_v[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Idle after reset
      repeat (10) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk("idle_rdy", 32'(rdy_v[d]), 32'd1);
            chk("idle_err", 32'(err_v[d]), 32'd0);
            chk("idle_rd_data", rd_v[d], 32'd0);
         end
      end
      @(posedge clk); #1;

      // Write then read, two wait states
      xfer(1, WRITE, 30'h005, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0, acc);
      xfer(1, READ,  30'h005, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, acc);
      repeat (3) @(negedge clk);
      chk("rd_hold", rd_v[1], 32'hDEAD_BEEF);
      @(posedge clk); #1;
      xfer(1, WRITE, 30'h006, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, acc);
      chk("rd_hold_after_write", rd_v[1], 32'hDEAD_BEEF);

      // Zero wait states
      xfer(0, WRITE, 30'h3FF, 32'h0000_1234, 1'b0, 32'h0, 1'b0, 1'b0, acc);
      xfer(0, READ,  30'h3FF, 32'h0,         1'b0, 32'h0000_1234, 1'b0, 1'b0, acc);
      xfer(0, READ,  30'h400, 32'h0,         1'b1, 32'h0, 1'b0, 1'b0, acc);

      // Out of range, no aliasing onto word 0
      xfer(1, WRITE, 30'h000, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, 1'b0, acc);
      xfer(1, WRITE, 30'h400, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 1'b0, acc);
      xfer(1, READ,  30'h000, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, acc);
      xfer(1, READ,  30'h400, 32'h0,         1'b1, 32'h0, 1'b0, 1'b0, acc);

      // Back-to-back reads, inputs scrambled while the responder is busy
      xfer(1, WRITE, 30'h001, 32'h1111_0001, 1'b0, 32'h0, 1'b0, 1'b0, acc);
      xfer(1, WRITE, 30'h002, 32'h2222_0002, 1'b0, 32'h0, 1'b0, 1'b0, acc);
      xfer(1, WRITE, 30'h003, 32'h3333_0003, 1'b0, 32'h0, 1'b0, 1'b0, acc);
      xfer(1, READ,  30'h001, 32'h0, 1'b0, 32'h1111_0001, 1'b1, 1'b1, a1);
      xfer(1, READ,  30'h002, 32'h0, 1'b0, 32'h2222_0002, 1'b1, 1'b1, a2);
      xfer(1, READ,  30'h003, 32'h0, 1'b0, 32'h3333_0003, 1'b0, 1'b1, a3);
      chk("b2b_spacing_1", a2 - a1, 32'd5);
      chk("b2b_spacing_2", a3 - a2, 32'd5);

      // Reset during the WAIT phase of a write
      xfer(1, WRITE, 30'h010, 32'h1111_2222, 1'b0, 32'h0, 1'b0, 1'b0, acc);
      as_v[1] = ENABLE_; addr_v[1] = 30'h010; rw_v[1] = WRITE; wd_v[1] = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      as_v[1] = DISABLE_;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("rdy_after_reset", 32'(rdy_v[1]), 32'd1);
      end
      chk("dut0_rd_data_after_reset", rd_v[0], 32'd0);
      @(posedge clk); #1;
      xfer(1, READ, 30'h010, 32'h0, 1'b0, 32'h1111_2222, 1'b0, 1'b0, acc);

      repeat (4) @(posedge clk);
      chk("queues_drained", q0.size() + q1.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
